// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side VGA timing recovery. Watches active-low hsync/vsync on pixel
// strobe cycles, rebuilds the pixel coordinate (hpos/vpos), measures the
// length of each completed line and frame, and declares lock once the
// incoming timing has matched H_TOTAL x V_TOTAL for LOCK_FRAMES consecutive
// frames. Loss of lock is flagged with a one-cycle err pulse.
//
// Parameters
//   H_TOTAL      expected pixels per line
//   V_TOTAL      expected lines per frame
//   LOCK_FRAMES  consecutive good frames needed to lock (1..15)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pix_en       one-cycle pixel strobe; nothing is sampled or counted without it
//   hsync_n      horizontal sync, active-low, synchronous to clk
//   vsync_n      vertical sync, active-low, synchronous to clk
//   hpos         pixel index in the current line (0 = hsync falling-edge pixel)
//   vpos         line index in the current frame (0 = first line after vsync fall)
//   line_len     length of the last complete line, in pixels
//   frame_lines  length of the last complete frame, in lines
//   locked       incoming timing matches the expected mode
//   err          one-cycle pulse when lock is lost
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       hsync_n,
    input  logic       vsync_n,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       locked,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    localparam logic [9:0] H_EXP  = 10'(H_TOTAL);
    localparam logic [9:0] V_EXP  = 10'(V_TOTAL);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    // Sync history and counters
    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic       armed_q, armed_d;
    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [9:0] line_len_q, line_len_d;
    logic [9:0] frame_lines_q, frame_lines_d;
    logic       vpend_q, vpend_d;

    // Lock tracking
    state_e     state_q, state_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic       frame_ok_q, frame_ok_d;
    logic       skip_q, skip_d;
    logic       locked_q;
    logic       err_q, err_d;

    logic       hfall, vfall, frame_start;
    logic       hpos_sat, line_bad, frame_len_ok;
    logic [9:0] line_len_new, frame_lines_new;
    logic [3:0] good_inc;

    // The history registers reset high, yet a sync line already held low when
    // reset releases must not look like a fresh edge. armed_q blocks edge
    // detection until the first post-reset pix_en sample has been taken.
    assign hfall = pix_en & armed_q & hs_prev_q & ~hsync_n;
    assign vfall = pix_en & armed_q & vs_prev_q & ~vsync_n;

    // A vsync fall is only acted on at the next hsync fall (or the same one).
    assign frame_start = hfall & (vpend_q | vfall);

    assign line_len_new    = hpos_q + 10'd1;
    assign frame_lines_new = vpos_q + 10'd1;
    assign frame_len_ok    = (frame_lines_new == V_EXP);
    assign good_inc        = good_cnt_q + 4'd1;

    // A runaway line is declared bad the moment hpos lands on its ceiling,
    // without waiting for an hsync that may never come.
    assign hpos_sat = pix_en & ~hfall & (hpos_q == CNT_MAX - 10'd1);

    // The first line measured after leaving SEARCH is exempt from the length check.
    assign line_bad = (hfall & ~skip_q & (line_len_new != H_EXP)) | hpos_sat;

    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        armed_d       = armed_q;
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        vpend_d       = vpend_q;
        skip_d        = skip_q;
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        frame_ok_d    = frame_ok_q;
        err_d         = 1'b0;

        if (pix_en) begin
            hs_prev_d = hsync_n;
            vs_prev_d = vsync_n;
            armed_d   = 1'b1;

            if (hfall) begin
                hpos_d     = '0;
                line_len_d = line_len_new;
                skip_d     = 1'b0;
            end else if (hpos_q != CNT_MAX) begin
                hpos_d = hpos_q + 10'd1;
            end

            if (frame_start) begin
                vpos_d        = '0;
                frame_lines_d = frame_lines_new;
                vpend_d       = 1'b0;
            end else begin
                if (hfall && (vpos_q != CNT_MAX)) begin
                    vpos_d = vpos_q + 10'd1;
                end
                if (vfall) begin
                    vpend_d = 1'b1;
                end
            end
        end

        case (state_q)
            ST_SEARCH: begin
                if (frame_start) begin
                    state_d    = ST_VERIFY;
                    good_cnt_d = '0;
                    frame_ok_d = 1'b1;
                    skip_d     = 1'b1;
                end
            end
            ST_VERIFY: begin
                // A bad closing line and a wrong frame height both fail the frame.
                if (frame_start) begin
                    if (frame_ok_q && !line_bad && frame_len_ok) begin
                        good_cnt_d = good_inc;
                        frame_ok_d = 1'b1;
                        if (good_inc == LOCK_N) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end else if (line_bad) begin
                    frame_ok_d = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (line_bad || (frame_start && !frame_len_ok)) begin
                    state_d = ST_SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            armed_q       <= 1'b0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            vpend_q       <= 1'b0;
            skip_q        <= 1'b0;
            state_q       <= ST_SEARCH;
            good_cnt_q    <= '0;
            frame_ok_q    <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            armed_q       <= armed_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            vpend_q       <= vpend_d;
            skip_q        <= skip_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            frame_ok_q    <= frame_ok_d;
            locked_q      <= (state_d == ST_LOCKED);
            err_q         <= err_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Drives a scaled-down VGA stream (20 x 12) into vga_sync_decoder and compares
// every clock against a behavioural model of the decoder rules, plus directed
// checks of lock timing, error pulses, saturation and reset behaviour.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int H_TOTAL     = 20;
    localparam int V_TOTAL     = 12;
    localparam int LOCK_FRAMES = 2;
    localparam int HS_W        = 3;

    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       pix_en  = 1'b0;
    logic       hsync_n = 1'b1;
    logic       vsync_n = 1'b1;
    logic [9:0] hpos, vpos, line_len, frame_lines;
    logic       locked, err;

    vga_sync_decoder #(
        .H_TOTAL    (H_TOTAL),
        .V_TOTAL    (V_TOTAL),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .locked     (locked),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_hprev, m_vprev, m_armed;
    int m_hpos, m_vpos, m_line_len, m_frame_lines;
    int m_vpend, m_state, m_good, m_frame_ok, m_skip, m_err;

    task automatic model_reset();
        m_hprev = 1; m_vprev = 1; m_armed = 0;
        m_hpos = 0; m_vpos = 0; m_line_len = 0; m_frame_lines = 0;
        m_vpend = 0; m_state = M_SEARCH; m_good = 0; m_frame_ok = 0;
        m_skip = 0; m_err = 0;
    endtask

    // Advances the model by one clock with the given inputs.
    task automatic model_step(input bit pe, input bit h, input bit v);
        int hf, vf, fs, bad, newlen, newfl;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_err = 0;
        if (!pe) return;
        hf = (m_armed != 0) && (m_hprev != 0) && !h;
        vf = (m_armed != 0) && (m_vprev != 0) && !v;
        fs = hf && (m_vpend != 0 || vf);
        bad = 0;
        newfl = 0;
        if (hf) begin
            newlen = (m_hpos + 1) % 1024;
            bad = (m_skip == 0) && (newlen != H_TOTAL);
            m_skip = 0;
            m_line_len = newlen;
            m_hpos = 0;
            if (fs) begin
                newfl = (m_vpos + 1) % 1024;
                m_frame_lines = newfl;
                m_vpos = 0;
                m_vpend = 0;
            end else if (m_vpos < 1023) begin
                m_vpos++;
            end
        end else begin
            if (m_hpos < 1023) begin
                m_hpos++;
                bad = (m_hpos == 1023);
            end
            if (vf) m_vpend = 1;
        end
        if (m_state == M_SEARCH) begin
            if (fs) begin
                m_state = M_VERIFY; m_good = 0; m_frame_ok = 1; m_skip = 1;
            end
        end else if (m_state == M_VERIFY) begin
            if (fs) begin
                if (m_frame_ok != 0 && !bad && newfl == V_TOTAL) begin
                    m_good++;
                    m_frame_ok = 1;
                    if (m_good == LOCK_FRAMES) m_state = M_LOCKED;
                end else begin
                    m_state = M_SEARCH;
                end
            end else if (bad) begin
                m_frame_ok = 0;
            end
        end else begin
            if (bad || (fs && newfl != V_TOTAL)) begin
                m_state = M_SEARCH;
                m_err = 1;
            end
        end
        m_armed = 1;
        m_hprev = h;
        m_vprev = v;
    endtask

    function automatic logic [63:0] model_vec();
        return 64'({10'(m_hpos), 10'(m_vpos), 10'(m_line_len), 10'(m_frame_lines),
                    (m_state == M_LOCKED), (m_err != 0)});
    endfunction

    // ---------------- stimulus helpers ----------------
    int gap_mode = 3;      // idle clocks between pixels; negative = random 0..3
    int n_err = 0;
    int err_len = 0;
    int err_fl = 0;
    int frames_started = 0;
    int rise_frame = -1;
    int rise_on_fs = 0;
    bit cur_fs = 1'b0;
    bit was_locked = 1'b0;

    task automatic tick(input bit pe, input bit h, input bit v);
        @(negedge clk);
        pix_en  = pe;
        hsync_n = h;
        vsync_n = v;
        @(posedge clk);
        #1;
        model_step(pe, h, v);
        check("outputs", 64'({hpos, vpos, line_len, frame_lines, locked, err}), model_vec());
        if (err) begin
            n_err++;
            err_len = int'(line_len);
            err_fl  = int'(frame_lines);
        end
        if (locked && !was_locked) begin
            rise_frame = frames_started;
            rise_on_fs = int'(cur_fs);
        end
        was_locked = locked;
    endtask

    task automatic pix(input bit h, input bit v);
        int n;
        bit rh, rv;
        n = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
        for (int i = 0; i < n; i++) begin
            rh = 1'($urandom);
            rv = 1'($urandom);
            tick(1'b0, rh, rv);
        end
        tick(1'b1, h, v);
    endtask

    // One frame: hsync low for HS_W pixels at the start of each line, vsync
    // low for two lines beginning at pixel vs_pos of line 0.
    task automatic frame(input int nlines, input int bad_line, input int bad_len, input int vs_pos);
        int len;
        bit h, v;
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : H_TOTAL;
            for (int p = 0; p < len; p++) begin
                h = (p < HS_W) ? 1'b0 : 1'b1;
                v = !((l == 0 && p >= vs_pos) || l == 1 || (l == 2 && p < vs_pos));
                cur_fs = (vs_pos == 0 && l == 0 && p == 0) || (vs_pos > 0 && l == 1 && p == 0);
                if (cur_fs) frames_started++;
                pix(h, v);
                if (cur_fs) check("vpos_at_frame_start", 64'(vpos), 64'(0));
                if (vs_pos > 0 && l == 0 && p == len - 1)
                    check("vpos_before_hfall", 64'(vpos != 10'd0), 64'(1));
            end
        end
        cur_fs = 1'b0;
    endtask

    task automatic async_reset(input bit h);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", 64'({hpos, vpos, line_len, frame_lines, locked, err}), 64'(0));
        for (int i = 0; i < 3; i++) tick(1'b1, h, 1'b1);
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int e0, nl, bl, blen, vs;
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;

        // Get the counters moving, then reset mid-line with hsync held low.
        gap_mode = -1;
        for (int i = 0; i < 4; i++) pix(1'b1, 1'b1);
        frame(2, -1, 0, 0);
        pix(1'b0, 1'b1);
        pix(1'b0, 1'b1);
        async_reset(1'b0);
        for (int i = 0; i < 5; i++) pix(1'b0, 1'b1);
        check("no_hfall_after_reset", 64'(line_len), 64'(0));
        check("hpos_counts_after_reset", 64'(hpos), 64'(5));
        for (int i = 0; i < 4; i++) pix(1'b1, 1'b1);

        // Nominal stream, pixel every 4th clock.
        gap_mode = 3;
        frames_started = 0;
        frame(V_TOTAL, -1, 0, 0);
        frame(V_TOTAL, -1, 0, 0);
        check("not_locked_early", 64'(locked), 64'(0));
        frame(V_TOTAL, -1, 0, 0);
        frame(V_TOTAL, -1, 0, 0);
        check("lock_frame_index", 64'(rise_frame), 64'(3));
        check("lock_on_frame_start", 64'(rise_on_fs), 64'(1));
        check("nominal_locked", 64'(locked), 64'(1));
        check("nominal_line_len", 64'(line_len), 64'(H_TOTAL));
        check("nominal_frame_lines", 64'(frame_lines), 64'(V_TOTAL));
        check("nominal_hpos_end", 64'(hpos), 64'(H_TOTAL - 1));
        check("nominal_vpos_end", 64'(vpos), 64'(V_TOTAL - 1));

        // Short line while locked.
        gap_mode = -1;
        e0 = n_err;
        frame(V_TOTAL, 5, H_TOTAL - 1, 0);
        check("short_err_pulses", 64'(n_err - e0), 64'(1));
        check("short_line_len", 64'(err_len), 64'(H_TOTAL - 1));
        check("short_unlocked", 64'(locked), 64'(0));
        frame(V_TOTAL, -1, 0, 0);
        frame(V_TOTAL, -1, 0, 0);
        check("short_relock_wait", 64'(locked), 64'(0));
        frame(V_TOTAL, -1, 0, 0);
        check("short_relock", 64'(locked), 64'(1));

        // Frame one line short, then one line long.
        for (int k = 0; k < 2; k++) begin
            e0 = n_err;
            frame(V_TOTAL - 1 + 2 * k, -1, 0, 0);
            check("height_no_err_yet", 64'(n_err - e0), 64'(0));
            frame(V_TOTAL, -1, 0, 0);
            check("height_err_pulses", 64'(n_err - e0), 64'(1));
            check("height_frame_lines", 64'(err_fl), 64'(V_TOTAL - 1 + 2 * k));
            check("height_unlocked", 64'(locked), 64'(0));
            for (int i = 0; i < 3; i++) frame(V_TOTAL, -1, 0, 0);
            check("height_relock", 64'(locked), 64'(1));
        end

        // Lose lock, enter VERIFY, then hsync sticks high.
        frame(V_TOTAL + 1, -1, 0, 0);
        frame(V_TOTAL, -1, 0, 0);
        frame(2, -1, 0, 0);
        for (int i = 0; i < 1100; i++) pix(1'b1, 1'b1);
        check("stuck_hpos_sat", 64'(hpos), 64'(1023));
        check("stuck_unlocked", 64'(locked), 64'(0));
        for (int i = 0; i < 4; i++) frame(V_TOTAL, -1, 0, 0);
        check("stuck_resume_lock", 64'(locked), 64'(1));

        // vsync falling mid-line: frame start waits for the next hsync fall.
        frame(V_TOTAL, -1, 0, 7);
        check("midline_first_height", 64'(frame_lines), 64'(V_TOTAL + 1));
        frame(V_TOTAL, -1, 0, 7);
        check("midline_height", 64'(frame_lines), 64'(V_TOTAL));

        // Randomised frames against the model, with one mid-frame reset.
        for (int k = 0; k < 20; k++) begin
            nl = V_TOTAL;
            if ($urandom_range(0, 3) == 0) nl = ($urandom_range(0, 1) != 0) ? V_TOTAL + 1 : V_TOTAL - 1;
            bl = -1;
            if ($urandom_range(0, 4) == 0) bl = int'($urandom_range(3, nl - 1));
            blen = ($urandom_range(0, 1) != 0) ? H_TOTAL + 1 : H_TOTAL - 1;
            vs = 0;
            if ($urandom_range(0, 3) == 0) vs = int'($urandom_range(1, H_TOTAL - 2));
            if (k == 10) begin
                frame(5, -1, 0, 0);
                pix(1'b0, 1'b1);
                async_reset(1'b0);
                for (int i = 0; i < 3; i++) pix(1'b1, 1'b1);
            end
            frame(nl, bl, blen, vs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
